uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver; successor to the single-rate receiver that feeds the RX FIFO. Synchronises the asynchronous rx_data line, detects start bits with glitch rejection, and majority-votes each bit at its centre. Supports runtime baud divisor, parity (none/even/odd) and 1 or 2 stop bits. Presents each frame to the RX FIFO write port with per-frame error flags.

Parameters:
WIDTH, 8, data bits per frame (5..9), LSB first
OSR, 16, oversample ticks per bit (even, >= 8)
DIV_W, 16, width of baud_div

Ports:
clk  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
rx_data  in  1  serial line, idle high, asynchronous to clk
baud_div  in  DIV_W  oversample tick period minus one, in clk cycles
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2  in  1  1 = two stop bits checked
d_out  out  WIDTH  received data, valid while fifo_we_en high
fifo_we_en  out  1  one-cycle write strobe to RX FIFO
parity_err  out  1  qualifies fifo_we_en: parity mismatch
frame_err  out  1  qualifies fifo_we_en: a stop bit sampled 0
break_det  out  1  one-cycle pulse on line break
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: d_out=0, fifo_we_en=0, parity_err=0, frame_err=0, break_det=0, busy=0. Synchroniser flops reset to 1. FSM = IDLE. All counters = 0.
- Reset mid-frame aborts the frame. No strobe is generated.
- Synchroniser: two flops on rx_data. All logic uses the synchronised value rxs.
- Tick generator: div_cnt counts 0..baud_div. tick is high for the cycle in which div_cnt==baud_div, then div_cnt wraps to 0. baud_div=0 gives a tick every cycle. div_cnt is cleared on start detection, aligning the tick phase to the falling edge.
- os_cnt counts 0..OSR-1 on ticks and wraps at OSR-1. Bit sample = majority of rxs at os_cnt OSR/2-1, OSR/2 and OSR/2+1. The decision is taken on the OSR/2+1 tick.
- parity_mode and stop2 are latched on start detection. Changes mid-frame are ignored.
- FSM:
  IDLE: rxs==0 -> START, clear os_cnt and div_cnt.
  START: voted 1 -> IDLE (false start, no output). Voted 0 -> DATA.
  DATA: on each vote, shift into bit WIDTH-1 of the shift register (LSB arrives first). After WIDTH bits -> PARITY if parity enabled, else STOP1.
  PARITY: vote and compare. Even: XOR(data, pbit)==0. Odd: XOR(data, pbit)==1.
  STOP1: vote. If stop2 -> STOP2, else finish.
  STOP2: vote, then finish.
- Finish, on the final stop vote:
  - Normal: next cycle fifo_we_en=1 for exactly one clk, with d_out and the error flags valid in that same cycle. FSM -> IDLE, so the next start edge is accepted from the stop-bit centre onward.
  - Break (all data bits 0, parity bit 0 if enabled, and first stop 0): break_det pulses one clk, fifo_we_en stays 0. FSM -> BRK_WAIT.
  - BRK_WAIT: hold until rxs==1, then -> IDLE. Only one break_det per break.
- Error flags are combinationally held at 0 outside fifo_we_en cycles (registered with the strobe). A frame with errors is still written.
- Frame latency: fifo_we_en rises 1 clk after the final stop vote tick, plus 2 clk synchroniser delay relative to the line.

Decomposition:
- uart_pkg: parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD); rx_state_e (IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT); default OSR/WIDTH localparams.
- One sub-module, uart_baud_tick: div_cnt, tick output, sync-clear input. It is reused by the future transmitter.

Test Plan:
- OSR=16, baud_div=0, no parity, 1 stop; send 0xA5 -> one fifo_we_en pulse, d_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Even parity, 0x37 with parity bit 1 -> parity_err=0. Same frame with parity bit 0 -> fifo_we_en with parity_err=1, d_out=0x37.
- stop2=1; send 0x3C with second stop bit 0 -> d_out=0x3C, frame_err=1. Same frame with stop2=0 -> frame_err=0.
- Line low for 3 clk then high (baud_div=0) -> no fifo_we_en, busy returns to 0 by os_cnt OSR/2+2.
- Line low for 20 bit times, then high -> exactly one break_det, no fifo_we_en. Next frame 0x5A after line goes high -> d_out=0x5A.
- baud_div=3: two back-to-back 0xFF/0x00 frames -> two strobes, correct data. Assert rstn low mid-second frame -> no second strobe, all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, receiver FSM states and
// default frame geometry. Imported by the receiver, the baud tick generator
// and, later, the transmitter.
package uart_pkg;

  localparam int DEF_WIDTH = 8;   // data bits per frame
  localparam int DEF_OSR   = 16;  // oversample ticks per bit

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5,
    BRK_WAIT = 3'd6
  } rx_state_e;

  // The spare code 2'b11 behaves as "no parity".
  function automatic parity_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear of the divider (re-phases the tick)
//   baud_div  : tick period minus one, in clk cycles
//   tick      : high for the cycle in which div_cnt == baud_div
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // A clear cycle never ticks, so the first tick after a clear is always a
  // full period (baud_div + 1 cycles) later.
  assign tick = (div_cnt == baud_div) && !clr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == baud_div)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver feeding the RX FIFO write port.
//   clk, rstn   : clock, asynchronous active-low reset
//   rx_data     : asynchronous serial line, idle high
//   baud_div    : oversample tick period minus one (clk cycles)
//   parity_mode : 00 none, 01 even, 10 odd, 11 none (latched at start)
//   stop2       : check a second stop bit (latched at start)
//   d_out       : received data, valid while fifo_we_en is high
//   fifo_we_en  : one-cycle write strobe; the FIFO has no back-pressure, so
//                 every strobe is a completed frame that must be accepted.
//                 d_out, parity_err and frame_err are valid only with it.
//   parity_err  : parity mismatch for the strobed frame
//   frame_err   : a stop bit sampled 0 for the strobed frame
//   break_det   : one-cycle pulse per line break (no strobe for it)
//   busy        : FSM is not IDLE
//   dbg_state   : current FSM state, for observation only
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OSR   = DEF_OSR,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_data,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic [WIDTH-1:0] d_out,
  output logic             fifo_we_en,
  output logic             parity_err,
  output logic             frame_err,
  output logic             break_det,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int OS_W = $clog2(OSR);
  localparam logic [OS_W-1:0] OS_V0   = OS_W'(OSR/2 - 1);
  localparam logic [OS_W-1:0] OS_V1   = OS_W'(OSR/2);
  localparam logic [OS_W-1:0] OS_V2   = OS_W'(OSR/2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
  localparam logic [3:0]      BC_LAST = 4'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic             rx_s1, rxs;
  logic             tick, start_det, vote_tick, vote, finish;
  logic             first_stop, is_break, par_bad, frame_bad;
  logic [OS_W-1:0]  os_cnt;
  logic [3:0]       bit_cnt;
  logic             v0, v1;
  logic [WIDTH-1:0] shreg;
  parity_e          par_q;
  logic             stop2_q, pbit_q, stop1_q;
  logic             perr_q, ferr_q;

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx_data;
      rxs   <= rx_s1;
    end
  end

  assign start_det = (state_q == IDLE) && !rxs;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (start_det),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // Decision tick: the third of the three centre samples.
  assign vote_tick = tick && (os_cnt == OS_V2) &&
                     (state_q != IDLE) && (state_q != BRK_WAIT);
  assign vote      = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

  // The first stop bit is the live vote in STOP1, the stored one in STOP2.
  assign first_stop = (state_q == STOP1) ? vote : stop1_q;
  assign is_break   = (shreg == '0) && ((par_q == PAR_NONE) || !pbit_q) &&
                      !first_stop;
  assign frame_bad  = !first_stop || ((state_q == STOP2) && !vote);
  assign par_bad    = ((par_q == PAR_EVEN) && ((^shreg) ^ pbit_q)) ||
                      ((par_q == PAR_ODD)  && !((^shreg) ^ pbit_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE:     if (!rxs) state_d = START;
      START:    if (vote_tick) state_d = vote ? IDLE : DATA;
      DATA:     if (vote_tick && (bit_cnt == BC_LAST))
                  state_d = (par_q != PAR_NONE) ? PARITY : STOP1;
      PARITY:   if (vote_tick) state_d = STOP1;
      STOP1:    if (vote_tick) begin
                  if (stop2_q) state_d = STOP2;
                  else         finish  = 1'b1;
                end
      STOP2:    if (vote_tick) finish = 1'b1;
      BRK_WAIT: if (rxs) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (finish) state_d = is_break ? BRK_WAIT : IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      os_cnt     <= '0;
      bit_cnt    <= '0;
      v0         <= 1'b1;
      v1         <= 1'b1;
      shreg      <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      pbit_q     <= 1'b0;
      stop1_q    <= 1'b0;
      d_out      <= '0;
      fifo_we_en <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      fifo_we_en <= 1'b0;
      break_det  <= 1'b0;
      if (start_det) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
        par_q   <= decode_parity(parity_mode);
        stop2_q <= stop2;
      end else if (tick && (state_q != IDLE) && (state_q != BRK_WAIT)) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (os_cnt == OS_V0) v0 <= rxs;
        if (os_cnt == OS_V1) v1 <= rxs;
        if (vote_tick) begin
          case (state_q)
            DATA: begin
              shreg   <= {vote, shreg[WIDTH-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY:  pbit_q  <= vote;
            STOP1:   stop1_q <= vote;
            default: ;
          endcase
        end
      end
      if (finish) begin
        if (is_break) begin
          break_det <= 1'b1;
        end else begin
          fifo_we_en <= 1'b1;
          d_out      <= shreg;
          perr_q     <= par_bad;
          ferr_q     <= frame_bad;
        end
      end
    end
  end

  // Error flags only mean something alongside the strobe.
  assign parity_err = perr_q & fifo_we_en;
  assign frame_err  = ferr_q & fifo_we_en;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule
